// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU units.
// Provides the IDLE/RUN/DONE state encoding and a counter-width helper.
package alu_pkg;

    // Common three-phase handshake FSM encoding for multi-cycle ALU units
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Width of a counter that must hold values 0..w inclusive
    function automatic int alu_cnt_width(input int w);
        return (w < 1) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder cell: sum and carry-out from a, b and carry-in.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    // Plain combinational full adder
    always_comb begin
        sum_o  = a_i ^ b_i ^ cin_i;
        cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
// LSB first, computed as a + ~b + 1 through a single fa_cell.
// Optional macro SUB_SIGNED_FLAGS_EN adds the signed ovf/neg flag outputs.
module serial_subtractor
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
`ifdef SUB_SIGNED_FLAGS_EN
    ,
    output logic             ovf,
    output logic             neg
`endif
);

    localparam int               CNT_W    = alu_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    alu_state_e       state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_d;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             borrow_q;
    logic             zero_q;
`ifdef SUB_SIGNED_FLAGS_EN
    logic             ovf_q;
    logic             neg_q;
`endif

    logic cell_sum;
    logic cell_cout;

    // The only arithmetic in the block: one full adder with b inverted
    fa_cell u_fa (
        .a_i    (a_sr_q[0]),
        .b_i    (~b_sr_q[0]),
        .cin_i  (carry_q),
        .sum_o  (cell_sum),
        .cout_o (cell_cout)
    );

    // Next diff shift value: new sum bit enters at the MSB, older bits move down
    always_comb begin
        diff_d            = diff_q >> 1;
        diff_d[WIDTH-1]   = cell_sum;
    end

    // FSM, operand/result shift registers, bit counter and registered flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            diff_q      <= '0;
            carry_q     <= 1'b1;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            borrow_q    <= 1'b0;
            zero_q      <= 1'b0;
`ifdef SUB_SIGNED_FLAGS_EN
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_sr_q     <= a;
                        b_sr_q     <= b;
                        diff_q     <= '0;
                        carry_q    <= 1'b1;   // the +1 of a + ~b + 1
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    diff_q  <= diff_d;
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    carry_q <= cell_cout;
                    cnt_q   <= cnt_q + CNT_ONE;
                    if (cnt_q == LAST_BIT) begin
                        // Final bit: latch flags alongside the completed result.
                        // carry_q here is still the carry into the MSB.
                        borrow_q    <= ~cell_cout;
                        zero_q      <= (diff_d == '0);
`ifdef SUB_SIGNED_FLAGS_EN
                        ovf_q       <= carry_q ^ cell_cout;
                        neg_q       <= cell_sum;
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // All outputs come straight from registers
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = out_valid_q;
        diff      = diff_q;
        borrow    = borrow_q;
        zero      = zero_q;
`ifdef SUB_SIGNED_FLAGS_EN
        ovf       = ovf_q;
        neg       = neg_q;
`endif
    end

endmodule
